// File: rtl/vga_frame_reader.sv
// vga_frame_reader
//   Scanout stage between the frame-buffer SRAM read port and the VGA DAC.
//   Generates 640x480 VGA timing, walks a IMG_W x IMG_H image window in
//   row-major order issuing SRAM read addresses, and expands the returned
//   RGB332 bytes to 8 bits per channel with sync/blank aligned to the data.
//
//   Optional build macro:
//     VGA_BORDER_EN  - draw a 1-pixel white ring just outside the window.
//
// Ports:
//   CLK           in   system clock
//   RST_N         in   asynchronous active-low reset
//   pix_en        in   pixel tick; all state advances only when high
//   sram_address  out  registered SRAM read address for the current pixel
//   sram_enable   out  SRAM write enable, constant 0 (read only)
//   sram_data     in   SRAM read data for sram_address
//   vga_r/g/b     out  8-bit colour channels
//   vga_hsync     out  horizontal sync, active low
//   vga_vsync     out  vertical sync, active low
//   vga_blank_n   out  high while a visible pixel is driven
//   frame_start   out  one-CLK pulse marking the tick that loads pixel (0,0)

module vga_frame_reader #(
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter int IMG_W         = 224,
    parameter int IMG_H         = 180,
    parameter int IMG_X0        = 208,
    parameter int IMG_Y0        = 150,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR = 8'h00
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     pix_en,
    output logic [ADDRESS_WIDTH-1:0] sram_address,
    output logic                     sram_enable,
    input  logic [DATA_WIDTH-1:0]    sram_data,
    output logic [7:0]               vga_r,
    output logic [7:0]               vga_g,
    output logic [7:0]               vga_b,
    output logic                     vga_hsync,
    output logic                     vga_vsync,
    output logic                     vga_blank_n,
    output logic                     frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] WIN_X_BEG  = HW'(IMG_X0);
    localparam logic [HW-1:0] WIN_X_END  = HW'(IMG_X0 + IMG_W);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] WIN_Y_BEG  = VW'(IMG_Y0);
    localparam logic [VW-1:0] WIN_Y_END  = VW'(IMG_Y0 + IMG_H);

`ifdef VGA_BORDER_EN
    // Ring bounds are inclusive: one pixel beyond each window edge.
    localparam logic [HW-1:0] RING_X_BEG = HW'(IMG_X0 - 1);
    localparam logic [HW-1:0] RING_X_END = HW'(IMG_X0 + IMG_W);
    localparam logic [VW-1:0] RING_Y_BEG = VW'(IMG_Y0 - 1);
    localparam logic [VW-1:0] RING_Y_END = VW'(IMG_Y0 + IMG_H);
`endif

    logic [HW-1:0]            h_cnt;
    logic [VW-1:0]            v_cnt;
    logic [HW-1:0]            h_nxt;
    logic [VW-1:0]            v_nxt;
    logic                     h_wrap;
    logic                     v_wrap;
    logic                     frame_wrap;
    logic                     in_vis;
    logic                     in_win;
    logic                     hs;
    logic                     vs;
    logic                     win_nxt;
    logic [ADDRESS_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0]    pix_c;
`ifdef VGA_BORDER_EN
    logic                     ring;
`endif

    assign sram_enable = 1'b0;

    always_comb begin
        h_wrap     = (h_cnt == H_LAST);
        v_wrap     = (v_cnt == V_LAST);
        frame_wrap = h_wrap && v_wrap;
        h_nxt      = h_wrap ? '0 : h_cnt + HW'(1);
        v_nxt      = v_cnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_cnt + VW'(1);
        end

        in_vis = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        in_win = (h_cnt >= WIN_X_BEG) && (h_cnt < WIN_X_END) &&
                 (v_cnt >= WIN_Y_BEG) && (v_cnt < WIN_Y_END);
        hs     = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        vs     = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

        // The address is computed for the pixel being loaded into the
        // counters, so it is already settled when that pixel's colour is
        // registered one tick later.
        win_nxt  = (h_nxt >= WIN_X_BEG) && (h_nxt < WIN_X_END) &&
                   (v_nxt >= WIN_Y_BEG) && (v_nxt < WIN_Y_END);
        addr_nxt = ADDRESS_WIDTH'(v_nxt - WIN_Y_BEG) * ADDRESS_WIDTH'(IMG_W) +
                   ADDRESS_WIDTH'(h_nxt - WIN_X_BEG);

`ifdef VGA_BORDER_EN
        ring  = (h_cnt >= RING_X_BEG) && (h_cnt <= RING_X_END) &&
                (v_cnt >= RING_Y_BEG) && (v_cnt <= RING_Y_END) && !in_win;
        pix_c = in_win ? sram_data : (ring ? {DATA_WIDTH{1'b1}} : BG_COLOR);
`else
        pix_c = in_win ? sram_data : BG_COLOR;
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            sram_address <= '0;
            vga_r        <= '0;
            vga_g        <= '0;
            vga_b        <= '0;
            vga_hsync    <= 1'b1;
            vga_vsync    <= 1'b1;
            vga_blank_n  <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            // Not gated by a hold: the pulse drops after one CLK even when
            // the following CLK is not a pixel tick.
            frame_start <= pix_en && frame_wrap;
            if (pix_en) begin
                h_cnt <= h_nxt;
                v_cnt <= v_nxt;
                if (frame_wrap) begin
                    sram_address <= '0;
                end else if (win_nxt) begin
                    sram_address <= addr_nxt;
                end
                // RGB332 expansion by bit replication so full scale maps to 8'hFF.
                vga_r       <= in_vis ? {pix_c[7:5], pix_c[7:5], pix_c[7:6]} : 8'h00;
                vga_g       <= in_vis ? {pix_c[4:2], pix_c[4:2], pix_c[4:3]} : 8'h00;
                vga_b       <= in_vis ? {pix_c[1:0], pix_c[1:0], pix_c[1:0], pix_c[1:0]} : 8'h00;
                vga_hsync   <= ~hs;
                vga_vsync   <= ~vs;
                vga_blank_n <= in_vis;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
module tb_vga_frame_reader;

    // Reduced raster used for frame-level scenarios so whole frames fit in
    // a short run; the default-parameter instance covers real line timing.
    localparam int S_HV = 40, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int S_VV = 30, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_W = 12, S_H = 8, S_X0 = 10, S_Y0 = 9;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;   // 56
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;   // 37

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        pe_s, pe_f;

    logic [15:0] s_addr, f_addr;
    logic        s_en, f_en;
    logic [7:0]  s_data, f_data;
    logic [7:0]  s_r, s_g, s_b, f_r, f_g, f_b;
    logic        s_hs, s_vs, s_blank, s_fs;
    logic        f_hs, f_vs, f_blank, f_fs;

    logic [7:0]  mem [0:65535];
    assign s_data = mem[s_addr];
    assign f_data = mem[f_addr];

    int checks = 0;
    int passed = 0;

    int mh, mv, midx;
    logic [15:0] maddr;
    logic [26:0] q[$];

    logic [7:0]  col_byte [5];
    logic [23:0] col_exp  [5];

    always #5 CLK = ~CLK;

    vga_frame_reader #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .IMG_W(S_W), .IMG_H(S_H), .IMG_X0(S_X0), .IMG_Y0(S_Y0),
        .ADDRESS_WIDTH(16), .DATA_WIDTH(8), .BG_COLOR(8'h00)
    ) u_small (
        .CLK(CLK), .RST_N(RST_N), .pix_en(pe_s),
        .sram_address(s_addr), .sram_enable(s_en), .sram_data(s_data),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_blank_n(s_blank),
        .frame_start(s_fs)
    );

    vga_frame_reader u_full (
        .CLK(CLK), .RST_N(RST_N), .pix_en(pe_f),
        .sram_address(f_addr), .sram_enable(f_en), .sram_data(f_data),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
        .vga_hsync(f_hs), .vga_vsync(f_vs), .vga_blank_n(f_blank),
        .frame_start(f_fs)
    );

    // Expected pins {r,g,b,hsync_n,vsync_n,blank_n} for a raster position.
    function automatic logic [26:0] model_out(input int h, input int v, input logic [7:0] d);
        logic vis, win, brd;
        logic [7:0] c, r, g, b;
        vis = (h < S_HV) && (v < S_VV);
        win = (h >= S_X0) && (h < S_X0 + S_W) && (v >= S_Y0) && (v < S_Y0 + S_H);
        brd = 1'b0;
`ifdef VGA_BORDER_EN
        brd = (h >= S_X0 - 1) && (h <= S_X0 + S_W) && (v >= S_Y0 - 1) && (v <= S_Y0 + S_H) && !win;
`endif
        c = win ? d : (brd ? 8'hFF : 8'h00);
        r = vis ? {c[7:5], c[7:5], c[7:6]} : 8'h00;
        g = vis ? {c[4:2], c[4:2], c[4:3]} : 8'h00;
        b = vis ? {c[1:0], c[1:0], c[1:0], c[1:0]} : 8'h00;
        return {r, g, b,
                !((h >= S_HV + S_HF) && (h < S_HV + S_HF + S_HS)),
                !((v >= S_VV + S_VF) && (v < S_VV + S_VF + S_VS)),
                vis};
    endfunction

    // Reference addresses at a few landmark positions of the window walk.
    function automatic int lit_addr(input int h, input int v);
        if (h == S_X0 && v == S_Y0)                    return 0;
        if (h == S_X0 + S_W - 1 && v == S_Y0)          return S_W - 1;
        if (h == S_X0 && v == S_Y0 + 1)                return S_W;
        if (h == S_X0 + S_W - 1 && v == S_Y0 + S_H - 1) return S_W * S_H - 1;
        return -1;
    endfunction

    // Advance the reference raster by one tick; the address is kept as a
    // running count of window pixels rather than a row*width product.
    task automatic model_step(output logic fs);
        int nh, nv;
        nh = mh + 1;
        nv = mv;
        if (nh == S_HT) begin
            nh = 0;
            nv = mv + 1;
            if (nv == S_VT) nv = 0;
        end
        fs = (nh == 0) && (nv == 0);
        if (fs) begin
            maddr = 16'd0;
            midx  = 0;
        end else if ((nh >= S_X0) && (nh < S_X0 + S_W) && (nv >= S_Y0) && (nv < S_Y0 + S_H)) begin
            maddr = 16'(midx);
            midx++;
        end
        mh = nh;
        mv = nv;
    endtask

    task automatic do_reset();
        pe_s  = 1'b0;
        pe_f  = 1'b0;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        mh = 0; mv = 0; midx = 0; maddr = 16'd0;
        q.delete();
    endtask

    task automatic test_reset();
        logic [44:0] exp_v;
        exp_v = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0};
        RST_N = 1'b0; pe_s = 1'b1; pe_f = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({s_r, s_g, s_b, s_hs, s_vs, s_blank, s_fs, s_addr, s_en} !== exp_v)
            $display("FAIL reset_small got=%h exp=%h", {s_r, s_g, s_b, s_hs, s_vs, s_blank, s_fs, s_addr, s_en}, exp_v);
        else passed++;
        checks++;
        if ({f_r, f_g, f_b, f_hs, f_vs, f_blank, f_fs, f_addr, f_en} !== exp_v)
            $display("FAIL reset_full got=%h exp=%h", {f_r, f_g, f_b, f_hs, f_vs, f_blank, f_fs, f_addr, f_en}, exp_v);
        else passed++;
        pe_s = 1'b0; pe_f = 1'b0;
    endtask

    task automatic test_line_timing();
        int low_cnt, pos, fall1, fall2;
        logic prev_hs, exp_hs, exp_bl;
        logic [42:0] act, exp_v;
        low_cnt = 0; fall1 = 0; fall2 = 0; prev_hs = 1'b1;
        do_reset();
        for (int n = 1; n <= 1700; n++) begin
            pe_f = 1'b1;
            @(negedge CLK);
            pos    = (n - 1) % 800;
            exp_hs = !((pos >= 656) && (pos < 752));
            exp_bl = (pos < 640);
            act    = {f_r, f_g, f_b, f_hs, f_vs, f_blank, f_addr};
            exp_v  = {24'h0, exp_hs, 1'b1, exp_bl, 16'h0};
            checks++;
            if (act !== exp_v) $display("FAIL line_timing tick=%0d got=%h exp=%h", n, act, exp_v);
            else passed++;
            if (n <= 800 && f_hs === 1'b0) low_cnt++;
            if (prev_hs === 1'b1 && f_hs === 1'b0) begin
                if (fall1 == 0) fall1 = n;
                else if (fall2 == 0) fall2 = n;
            end
            prev_hs = f_hs;
        end
        pe_f = 1'b0;
        checks++;
        if (low_cnt != 96) $display("FAIL hsync_width got=%0d exp=96", low_cnt); else passed++;
        checks++;
        if (fall1 != 657) $display("FAIL hsync_start got=%0d exp=657", fall1); else passed++;
        checks++;
        if (fall2 - fall1 != 800) $display("FAIL hsync_period got=%0d exp=800", fall2 - fall1); else passed++;
    endtask

    task automatic test_colour();
        int pos, h, v;
        logic [23:0] brd_exp;
`ifdef VGA_BORDER_EN
        brd_exp = 24'hFFFFFF;
`else
        brd_exp = 24'h000000;
`endif
        for (int k = 0; k < 5; k++) mem[k] = col_byte[k];
        do_reset();
        for (int n = 1; n <= 520; n++) begin
            pe_s = 1'b1;
            @(negedge CLK);
            pos = n - 1;
            h = pos % S_HT;
            v = pos / S_HT;
            if (v == S_Y0 && h >= S_X0 && h < S_X0 + 5) begin
                checks++;
                if ({s_r, s_g, s_b, s_blank} !== {col_exp[h - S_X0], 1'b1})
                    $display("FAIL colour byte=%h got=%h exp=%h", col_byte[h - S_X0], {s_r, s_g, s_b, s_blank}, {col_exp[h - S_X0], 1'b1});
                else passed++;
            end
            if (v == S_Y0 && h == S_X0 - 1) begin
                checks++;
                if ({s_r, s_g, s_b, s_blank} !== {brd_exp, 1'b1})
                    $display("FAIL edge_pixel got=%h exp=%h", {s_r, s_g, s_b, s_blank}, {brd_exp, 1'b1});
                else passed++;
            end
            if (v == S_Y0 && h == 5) begin
                checks++;
                if ({s_r, s_g, s_b, s_blank} !== {24'h0, 1'b1})
                    $display("FAIL background got=%h exp=%h", {s_r, s_g, s_b, s_blank}, {24'h0, 1'b1});
                else passed++;
            end
        end
        pe_s = 1'b0;
        for (int k = 0; k < 5; k++) mem[k] = 8'(k);
    endtask

    task automatic test_reset_mid_frame();
        logic [44:0] exp_v;
        exp_v = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0};
        do_reset();
        for (int n = 1; n <= 521; n++) begin
            pe_s = 1'b1; pe_f = 1'b1;
            @(negedge CLK);
        end
        checks++;
        if ({s_addr, s_b, f_blank} !== {16'd7, 8'hAA, 1'b1})
            $display("FAIL pre_reset got=%h exp=%h", {s_addr, s_b, f_blank}, {16'd7, 8'hAA, 1'b1});
        else passed++;
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({s_r, s_g, s_b, s_hs, s_vs, s_blank, s_fs, s_addr, s_en} !== exp_v)
            $display("FAIL mid_reset_small got=%h exp=%h", {s_r, s_g, s_b, s_hs, s_vs, s_blank, s_fs, s_addr, s_en}, exp_v);
        else passed++;
        checks++;
        if ({f_r, f_g, f_b, f_hs, f_vs, f_blank, f_fs, f_addr, f_en} !== exp_v)
            $display("FAIL mid_reset_full got=%h exp=%h", {f_r, f_g, f_b, f_hs, f_vs, f_blank, f_fs, f_addr, f_en}, exp_v);
        else passed++;
        pe_s = 1'b0; pe_f = 1'b0;
    endtask

    // Scoreboard scan: stride 1 is the plain address walk, stride 2 the
    // stalled run where every other CLK must hold all outputs.
    task automatic test_scan(input int stride, input int nticks);
        int ticks, cyc, first_fs, la;
        logic tick, exp_fs;
        logic [26:0] exp_o, last_o, act;
        ticks = 0; cyc = 0; first_fs = 0; exp_fs = 1'b0;
        do_reset();
        last_o = {24'h0, 1'b1, 1'b1, 1'b0};
        while (ticks < nticks) begin
            tick = ((cyc % stride) == 0);
            pe_s = tick;
            if (tick) begin
                q.push_back(model_out(mh, mv, mem[maddr]));
                model_step(exp_fs);
                ticks++;
            end
            @(negedge CLK);
            act = {s_r, s_g, s_b, s_hs, s_vs, s_blank};
            if (tick) begin
                exp_o  = q.pop_front();
                last_o = exp_o;
                checks++;
                if (act !== exp_o) $display("FAIL scan_pixel stride=%0d tick=%0d got=%h exp=%h", stride, ticks, act, exp_o);
                else passed++;
                checks++;
                if (s_fs !== exp_fs) $display("FAIL frame_start stride=%0d tick=%0d got=%b exp=%b", stride, ticks, s_fs, exp_fs);
                else passed++;
                if (s_fs === 1'b1 && first_fs == 0) first_fs = ticks;
            end else begin
                checks++;
                if (act !== last_o) $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, act, last_o);
                else passed++;
                checks++;
                if (s_fs !== 1'b0) $display("FAIL stall_frame_start cyc=%0d got=%b exp=0", cyc, s_fs);
                else passed++;
            end
            checks++;
            if (s_addr !== maddr) $display("FAIL scan_addr stride=%0d cyc=%0d got=%0d exp=%0d", stride, cyc, s_addr, maddr);
            else passed++;
            la = lit_addr(mh, mv);
            if (la >= 0) begin
                checks++;
                if (s_addr !== 16'(la)) $display("FAIL landmark_addr h=%0d v=%0d got=%0d exp=%0d", mh, mv, s_addr, la);
                else passed++;
            end
            cyc++;
        end
        pe_s = 1'b0;
        checks++;
        if (first_fs != S_HT * S_VT) $display("FAIL first_frame_start stride=%0d got=%0d exp=%0d", stride, first_fs, S_HT * S_VT);
        else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        col_byte[0] = 8'hE0; col_exp[0] = 24'hFF0000;
        col_byte[1] = 8'h1C; col_exp[1] = 24'h00FF00;
        col_byte[2] = 8'h03; col_exp[2] = 24'h0000FF;
        col_byte[3] = 8'h92; col_exp[3] = 24'h9292AA;
        col_byte[4] = 8'h8A; col_exp[4] = 24'h9249AA;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
        RST_N = 1'b0; pe_s = 1'b0; pe_f = 1'b0;

        test_reset();
        test_line_timing();
        test_reset_mid_frame();
        test_colour();
        test_scan(1, 2 * S_HT * S_VT + 100);
        test_scan(2, S_HT * S_VT + 128);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
